// File: rtl/mem_responder.sv
// Wait-stated data-memory responder: word array with byte-lane writes, registered read data,
// and a pipeline hold. Optional range checking is enabled by defining MEM_RESP_BOUNDS_EN.
module mem_responder #(
    parameter int          ADDR_WIDTH  = 12,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        Rst_n,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_din,
    input  logic [3:0]  mem_en,
    input  logic        mem_wea,
    input  logic        mem_rea,
    output logic [31:0] mem_dout,
    output logic        mem_hold,
    output logic        mem_err
);

    localparam int         DEPTH    = 1 << ADDR_WIDTH;
    localparam logic       HAS_WAIT = (WAIT_STATES > 0);
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    logic [31:0] addr_q;
    logic [31:0] din_q;
    logic [3:0]  en_q;
    logic        wr_q;

    logic        req;
    logic        latch_en;
    logic        acc_fire;
    logic [31:0] acc_addr;
    logic [31:0] acc_din;
    logic [3:0]  acc_en;
    logic        acc_wr;

    logic [31:0]           acc_off;
    logic [ADDR_WIDTH-1:0] acc_idx;
    logic                  in_range;
    logic                  array_we;
    logic [31:0]           dout_q;

    logic [31:0] mem_q [DEPTH];

    assign req = (mem_wea | mem_rea) & (mem_en != 4'b0000);

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req && HAS_WAIT) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // In WAIT the latched copy drives the access; the live bus is only used from IDLE.
    always_comb begin
        mem_hold = 1'b0;
        latch_en = 1'b0;
        acc_fire = 1'b0;
        acc_addr = mem_addr;
        acc_din  = mem_din;
        acc_en   = mem_en;
        acc_wr   = mem_wea;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (HAS_WAIT) begin
                        mem_hold = Rst_n;
                        latch_en = 1'b1;
                    end else begin
                        acc_fire = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                mem_hold = Rst_n;
                acc_addr = addr_q;
                acc_din  = din_q;
                acc_en   = en_q;
                acc_wr   = wr_q;
                acc_fire = (cnt_q == 4'd0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (latch_en) begin
            addr_q <= mem_addr;
            din_q  <= mem_din;
            en_q   <= mem_en;
            wr_q   <= mem_wea;
        end
    end

    assign acc_off = acc_addr - BASE_ADDR;
    assign acc_idx = acc_off[ADDR_WIDTH+1:2];

`ifdef MEM_RESP_BOUNDS_EN
    localparam logic [33:0] SPAN = 34'(DEPTH) << 2;
    logic err_q;

    assign in_range = (acc_addr >= BASE_ADDR) && ({2'b00, acc_off} < SPAN);

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= acc_fire & ~in_range;
        end
    end

    assign mem_err = err_q;
`else
    assign in_range = 1'b1;
    assign mem_err  = 1'b0;
`endif

    logic unused_off_bits;
    assign unused_off_bits = ^{acc_off[31:ADDR_WIDTH+2], acc_off[1:0]};

    // Reset gates the write strobe so an aborted access can never touch the array.
    assign array_we = acc_fire & acc_wr & in_range & Rst_n;

    always_ff @(posedge clk) begin
        if (array_we) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_en[b]) begin
                    mem_q[acc_idx][8*b +: 8] <= acc_din[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            dout_q <= 32'h0000_0000;
        end else if (acc_fire && !acc_wr) begin
            dout_q <= in_range ? mem_q[acc_idx] : 32'hDEAD_BEEF;
        end
    end

    assign mem_dout = dout_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: three instances (2, 0 and 4 wait states) driven by
// directed accesses; a monitor pops expectations whenever an access completes.
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [3];
    logic [31:0] addr  [3];
    logic [31:0] din   [3];
    logic [3:0]  en    [3];
    logic        we    [3];
    logic        re    [3];
    logic [31:0] dout  [3];
    logic        hold  [3];
    logic        err   [3];

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            mem_responder #(
                .ADDR_WIDTH (12),
                .WAIT_STATES(g == 0 ? 2 : (g == 1 ? 0 : 4)),
                .BASE_ADDR  (32'h0000_0000)
            ) u_dut (
                .clk     (clk),
                .Rst_n   (rst_n[g]),
                .mem_addr(addr[g]),
                .mem_din (din[g]),
                .mem_en  (en[g]),
                .mem_wea (we[g]),
                .mem_rea (re[g]),
                .mem_dout(dout[g]),
                .mem_hold(hold[g]),
                .mem_err (err[g])
            );
        end
    endgenerate

    function automatic int ws_of(input int i);
        case (i)
            0:       return 2;
            1:       return 0;
            default: return 4;
        endcase
    endfunction

    typedef struct {
        int          inst;
        logic [31:0] dout;
        logic        err;
        int          seq;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          seq      = 0;
    logic [31:0] last_dout [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: an access completes in DONE (hold falling) or, with no wait states,
    // in the cycle after a request was sampled.
    logic req_prev  [3];
    logic hold_prev [3];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++)
            req_prev[i] <= rst_n[i] && (we[i] || re[i]) && (en[i] != 4'b0000);
    end

    always @(negedge clk) begin : mon
        logic done_now;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            done_now = (ws_of(i) == 0) ? req_prev[i] : (hold_prev[i] && !hold[i]);
            if (rst_n[i] && done_now) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_completion inst%0d: got completion expected none", i);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("order inst%0d seq%0d", i, e.seq), 32'(i), 32'(e.inst));
                    check($sformatf("dout inst%0d seq%0d", i, e.seq), dout[i], e.dout);
                    check($sformatf("err inst%0d seq%0d", i, e.seq), 32'(err[i]), 32'(e.err));
                end
            end
            hold_prev[i] = hold[i];
        end
    end

    // Entered just after a rising edge; leaves just after the edge following the access.
    task automatic access(input int i, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] e, input logic w, input logic r,
                          input logic [31:0] rd_exp, input logic err_exp);
        exp_t x;
        x.inst = i;
        x.err  = err_exp;
        x.seq  = seq;
        seq++;
        if (r && !w) begin
            x.dout       = rd_exp;
            last_dout[i] = rd_exp;
        end else begin
            x.dout = last_dout[i];
        end
        sb.push_back(x);
        addr[i] = a;
        din[i]  = d;
        en[i]   = e;
        we[i]   = w;
        re[i]   = r;
        if (ws_of(i) > 0) begin
            for (int c = 0; c <= ws_of(i); c++) begin
                @(negedge clk);
                check($sformatf("hold_busy inst%0d seq%0d c%0d", i, x.seq, c), 32'(hold[i]), 32'd1);
                @(posedge clk);
                #1;
            end
            @(negedge clk);
            check($sformatf("hold_done inst%0d seq%0d", i, x.seq), 32'(hold[i]), 32'd0);
            @(posedge clk);
            #1;
        end else begin
            @(negedge clk);
            check($sformatf("hold_zero inst%0d seq%0d", i, x.seq), 32'(hold[i]), 32'd0);
            @(posedge clk);
            #1;
        end
        we[i] = 1'b0;
        re[i] = 1'b0;
        en[i] = 4'b0000;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_n[i]     = 1'b0;
            addr[i]      = 32'h0;
            din[i]       = 32'h0;
            en[i]        = 4'h0;
            we[i]        = 1'b0;
            re[i]        = 1'b0;
            last_dout[i] = 32'h0;
            hold_prev[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_dout inst%0d", i), dout[i], 32'h0);
            check($sformatf("reset_hold inst%0d", i), 32'(hold[i]), 32'd0);
            check($sformatf("reset_err inst%0d", i), 32'(err[i]), 32'd0);
        end
        @(posedge clk);
        #1;

        // Two wait states: word write/read, byte lanes, simultaneous op, ignored low bits.
        access(0, 32'h40, 32'h1234_5678, 4'hF, 1'b1, 1'b0, 32'h0, 1'b0);
        access(0, 32'h40, 32'h0, 4'hF, 1'b0, 1'b1, 32'h1234_5678, 1'b0);
        access(0, 32'h80, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b0, 32'h0, 1'b0);
        access(0, 32'h80, 32'h0000_AB00, 4'b0010, 1'b1, 1'b0, 32'h0, 1'b0);
        access(0, 32'h80, 32'h0, 4'hF, 1'b0, 1'b1, 32'hFFFF_ABFF, 1'b0);
        access(0, 32'h20, 32'h5555_AAAA, 4'hF, 1'b1, 1'b1, 32'h0, 1'b0);
        access(0, 32'h20, 32'h0, 4'hF, 1'b0, 1'b1, 32'h5555_AAAA, 1'b0);
        access(0, 32'h43, 32'h0, 4'hF, 1'b0, 1'b1, 32'h1234_5678, 1'b0);

        // Lane enables of zero are not a request.
        addr[0] = 32'h40;
        din[0]  = 32'h0;
        en[0]   = 4'b0000;
        we[0]   = 1'b1;
        @(negedge clk);
        check("no_req_hold", 32'(hold[0]), 32'd0);
        @(posedge clk);
        #1;
        we[0] = 1'b0;
        access(0, 32'h40, 32'h0, 4'hF, 1'b0, 1'b1, 32'h1234_5678, 1'b0);

        access(0, 32'h0, 32'h1111_0000, 4'hF, 1'b1, 1'b0, 32'h0, 1'b0);
`ifdef MEM_RESP_BOUNDS_EN
        access(0, 32'h4000, 32'h0, 4'hF, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        @(negedge clk);
        check("err_pulse_end", 32'(err[0]), 32'd0);
        @(posedge clk);
        #1;
        access(0, 32'h4000, 32'h7777_7777, 4'hF, 1'b1, 1'b0, 32'h0, 1'b1);
        access(0, 32'h0, 32'h0, 4'hF, 1'b0, 1'b1, 32'h1111_0000, 1'b0);
`else
        access(0, 32'h4000, 32'h0, 4'hF, 1'b0, 1'b1, 32'h1111_0000, 1'b0);
        @(negedge clk);
        check("err_tied_low", 32'(err[0]), 32'd0);
        @(posedge clk);
        #1;
        access(0, 32'h4004, 32'h2222_0000, 4'hF, 1'b1, 1'b0, 32'h0, 1'b0);
        access(0, 32'h4, 32'h0, 4'hF, 1'b0, 1'b1, 32'h2222_0000, 1'b0);
`endif

        // Zero wait states: back-to-back alternating write/read.
        for (int k = 0; k < 8; k++) begin
            access(1, 32'(4 * k), 32'hA000_0000 + 32'(k), 4'hF, 1'b1, 1'b0, 32'h0, 1'b0);
            access(1, 32'(4 * k), 32'h0, 4'hF, 1'b0, 1'b1, 32'hA000_0000 + 32'(k), 1'b0);
        end

        // Four wait states: reset in the second WAIT cycle aborts a pending write.
        access(2, 32'h10, 32'h0BAD_0010, 4'hF, 1'b1, 1'b0, 32'h0, 1'b0);
        access(2, 32'h10, 32'h0, 4'hF, 1'b0, 1'b1, 32'h0BAD_0010, 1'b0);
        addr[2] = 32'h10;
        din[2]  = 32'hCAFE_0001;
        en[2]   = 4'hF;
        we[2]   = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n[2] = 1'b0;
        #1;
        check("abort_hold", 32'(hold[2]), 32'd0);
        check("abort_dout", dout[2], 32'h0);
        we[2] = 1'b0;
        en[2] = 4'h0;
        @(posedge clk);
        #1;
        rst_n[2]     = 1'b1;
        last_dout[2] = 32'h0;
        @(negedge clk);
        check("post_abort_hold", 32'(hold[2]), 32'd0);
        check("post_abort_dout", dout[2], 32'h0);
        @(posedge clk);
        #1;
        access(2, 32'h10, 32'h0, 4'hF, 1'b0, 1'b1, 32'h0BAD_0010, 1'b0);

        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("scoreboard_drain", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
